// File: rtl/vga_timing_pkg.sv
// Shared VGA 640x480@60 timing constants and the per-axis phase encoding.
package vga_timing_pkg;

    localparam int unsigned H_DISPLAY_DEF = 640;
    localparam int unsigned H_FRONT_DEF   = 16;
    localparam int unsigned H_SYNC_DEF    = 96;
    localparam int unsigned H_BACK_DEF    = 48;

    localparam int unsigned V_DISPLAY_DEF = 480;
    localparam int unsigned V_FRONT_DEF   = 10;
    localparam int unsigned V_SYNC_DEF    = 2;
    localparam int unsigned V_BACK_DEF    = 33;

    function automatic int unsigned axis_total(input int unsigned disp, input int unsigned front,
                                               input int unsigned sync, input int unsigned back);
        return disp + front + sync + back;
    endfunction

    localparam int unsigned H_TOTAL = axis_total(H_DISPLAY_DEF, H_FRONT_DEF, H_SYNC_DEF, H_BACK_DEF);
    localparam int unsigned V_TOTAL = axis_total(V_DISPLAY_DEF, V_FRONT_DEF, V_SYNC_DEF, V_BACK_DEF);

    // Sync windows are [START, END): END is the first count after the pulse.
    localparam int unsigned H_SYNC_START = H_DISPLAY_DEF + H_FRONT_DEF;
    localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC_DEF;
    localparam int unsigned V_SYNC_START = V_DISPLAY_DEF + V_FRONT_DEF;
    localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC_DEF;

    typedef enum logic [1:0] {
        ACTIVE,
        FRONT,
        SYNC,
        BACK
    } phase_e;

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis: wrapping position counter plus ACTIVE/FRONT/SYNC/BACK phase FSM.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int unsigned WIDTH     = 10,
    parameter int unsigned DISP_LEN  = 640,
    parameter int unsigned FRONT_LEN = 16,
    parameter int unsigned SYNC_LEN  = 96,
    parameter int unsigned BACK_LEN  = 48
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             adv_i,
    output logic [WIDTH-1:0] cnt_o,
    output logic             wrap_o,
    output logic             sync_nxt_o,
    output logic             vis_nxt_o
);

    localparam int unsigned      TOTAL    = axis_total(DISP_LEN, FRONT_LEN, SYNC_LEN, BACK_LEN);
    localparam logic [WIDTH-1:0] LAST     = WIDTH'(TOTAL - 1);
    localparam logic [WIDTH-1:0] FRONT_AT = WIDTH'(DISP_LEN);
    localparam logic [WIDTH-1:0] SYNC_AT  = WIDTH'(DISP_LEN + FRONT_LEN);
    localparam logic [WIDTH-1:0] BACK_AT  = WIDTH'(DISP_LEN + FRONT_LEN + SYNC_LEN);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    phase_e           phase_q, phase_d;

    assign wrap_o = adv_i && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (adv_i) begin
            cnt_d = wrap_o ? '0 : cnt_q + WIDTH'(1);
        end
    end

    // Phase moves on the advance that lands the count on the next boundary.
    always_comb begin
        phase_d = phase_q;
        if (adv_i) begin
            case (phase_q)
                ACTIVE:  if (cnt_d == FRONT_AT) phase_d = FRONT;
                FRONT:   if (cnt_d == SYNC_AT)  phase_d = SYNC;
                SYNC:    if (cnt_d == BACK_AT)  phase_d = BACK;
                BACK:    if (cnt_d == '0)       phase_d = ACTIVE;
                default: phase_d = ACTIVE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q   <= '0;
            phase_q <= ACTIVE;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    assign cnt_o      = cnt_q;
    assign sync_nxt_o = (phase_d == SYNC);
    assign vis_nxt_o  = (phase_d == ACTIVE);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator (pixel divider, H/V axes, registered syncs and strobes).
// Optional 16-bit frame counter output enabled by defining VGA_FRAME_COUNT_EN.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned CLK_DIV   = 4,
    parameter int unsigned H_DISPLAY = H_DISPLAY_DEF,
    parameter int unsigned H_FRONT   = H_FRONT_DEF,
    parameter int unsigned H_SYNC    = H_SYNC_DEF,
    parameter int unsigned H_BACK    = H_BACK_DEF,
    parameter int unsigned V_DISPLAY = V_DISPLAY_DEF,
    parameter int unsigned V_FRONT   = V_FRONT_DEF,
    parameter int unsigned V_SYNC    = V_SYNC_DEF,
    parameter int unsigned V_BACK    = V_BACK_DEF
) (
    input  logic        i_clock,
    input  logic        i_reset,
    output logic        o_hsync,
    output logic        o_vsync,
    output logic        o_display_on,
    output logic [9:0]  o_h_spot,
    output logic [9:0]  o_v_spot,
    output logic        o_pixel_tick,
`ifdef VGA_FRAME_COUNT_EN
    output logic [15:0] o_frame_count,
`endif
    output logic        o_frame_start
);

    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DIV_W-1:0] div_q, div_d;
    logic             pix_adv;
    logic             h_wrap, v_wrap;
    logic             h_sync_nxt, v_sync_nxt;
    logic             h_vis_nxt, v_vis_nxt;

    assign pix_adv = (div_q == DIV_W'(CLK_DIV - 1));

    always_comb begin
        div_d = pix_adv ? '0 : div_q + DIV_W'(1);
    end

    vga_axis_counter #(
        .WIDTH     (10),
        .DISP_LEN  (H_DISPLAY),
        .FRONT_LEN (H_FRONT),
        .SYNC_LEN  (H_SYNC),
        .BACK_LEN  (H_BACK)
    ) u_h_axis (
        .clk_i      (i_clock),
        .rst_i      (i_reset),
        .adv_i      (pix_adv),
        .cnt_o      (o_h_spot),
        .wrap_o     (h_wrap),
        .sync_nxt_o (h_sync_nxt),
        .vis_nxt_o  (h_vis_nxt)
    );

    vga_axis_counter #(
        .WIDTH     (10),
        .DISP_LEN  (V_DISPLAY),
        .FRONT_LEN (V_FRONT),
        .SYNC_LEN  (V_SYNC),
        .BACK_LEN  (V_BACK)
    ) u_v_axis (
        .clk_i      (i_clock),
        .rst_i      (i_reset),
        .adv_i      (h_wrap),
        .cnt_o      (o_v_spot),
        .wrap_o     (v_wrap),
        .sync_nxt_o (v_sync_nxt),
        .vis_nxt_o  (v_vis_nxt)
    );

    // Outputs load from the axes' next-state decode so they switch with the counters.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            div_q         <= '0;
            o_hsync       <= 1'b1;
            o_vsync       <= 1'b1;
            o_display_on  <= 1'b1;
            o_pixel_tick  <= 1'b0;
            o_frame_start <= 1'b0;
        end else begin
            div_q         <= div_d;
            o_hsync       <= ~h_sync_nxt;
            o_vsync       <= ~v_sync_nxt;
            o_display_on  <= h_vis_nxt & v_vis_nxt;
            o_pixel_tick  <= pix_adv;
            o_frame_start <= v_wrap;
        end
    end

`ifdef VGA_FRAME_COUNT_EN
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            o_frame_count <= '0;
        end else if (v_wrap) begin
            o_frame_count <= o_frame_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen on a shrunken raster (15x12 pixels, divide by 3).
module tb_vga_timing_gen;

    localparam int unsigned CLK_DIV = 3;
    localparam int unsigned HD = 8, HF = 2, HS = 3, HB = 2;
    localparam int unsigned VD = 6, VF = 2, VS = 2, VB = 2;
    localparam int unsigned HT = HD + HF + HS + HB;
    localparam int unsigned VT = VD + VF + VS + VB;
    localparam int unsigned HSS = HD + HF, HSE = HD + HF + HS;
    localparam int unsigned VSS = VD + VF, VSE = VD + VF + VS;
    localparam int unsigned LINE  = HT * CLK_DIV;
    localparam int unsigned FRAME = LINE * VT;

    logic       clk;
    logic       rst;
    logic       o_hsync, o_vsync, o_display_on, o_pixel_tick, o_frame_start;
    logic [9:0] o_h_spot, o_v_spot;
`ifdef VGA_FRAME_COUNT_EN
    logic [15:0] o_frame_count;
`endif

    int checks = 0;
    int errors = 0;

    vga_timing_gen #(
        .CLK_DIV   (CLK_DIV),
        .H_DISPLAY (HD), .H_FRONT (HF), .H_SYNC (HS), .H_BACK (HB),
        .V_DISPLAY (VD), .V_FRONT (VF), .V_SYNC (VS), .V_BACK (VB)
    ) dut (
        .i_clock       (clk),
        .i_reset       (rst),
        .o_hsync       (o_hsync),
        .o_vsync       (o_vsync),
        .o_display_on  (o_display_on),
        .o_h_spot      (o_h_spot),
        .o_v_spot      (o_v_spot),
        .o_pixel_tick  (o_pixel_tick),
`ifdef VGA_FRAME_COUNT_EN
        .o_frame_count (o_frame_count),
`endif
        .o_frame_start (o_frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [9:0] h;
        logic [9:0] v;
        logic       hs;
        logic       vs;
        logic       de;
        logic       tick;
        logic       fs;
    } exp_t;

    exp_t        sb[$];
    exp_t        m_exp;
    exp_t        c_exp;
    exp_t        c_act;
    int unsigned m_div, m_h, m_v;
    bit          m_adv, m_hw, m_vw;

    // Reference raster model: expected outputs are queued at every active edge.
    always @(posedge clk) begin
        m_adv = 1'b0;
        m_hw  = 1'b0;
        m_vw  = 1'b0;
        if (rst) begin
            m_div = 0;
            m_h   = 0;
            m_v   = 0;
        end else begin
            m_adv = (m_div == CLK_DIV - 1);
            m_div = m_adv ? 0 : m_div + 1;
            if (m_adv) begin
                m_hw = (m_h == HT - 1);
                m_h  = m_hw ? 0 : m_h + 1;
                if (m_hw) begin
                    m_vw = (m_v == VT - 1);
                    m_v  = m_vw ? 0 : m_v + 1;
                end
            end
        end
        m_exp.h    = 10'(m_h);
        m_exp.v    = 10'(m_v);
        m_exp.hs   = !(m_h >= HSS && m_h < HSE);
        m_exp.vs   = !(m_v >= VSS && m_v < VSE);
        m_exp.de   = (m_h < HD) && (m_v < VD);
        m_exp.tick = m_adv;
        m_exp.fs   = m_vw;
        sb.push_back(m_exp);
    end

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            c_exp = sb.pop_front();
            c_act = {o_h_spot, o_v_spot, o_hsync, o_vsync, o_display_on, o_pixel_tick, o_frame_start};
            checks++;
            if (c_act !== c_exp) begin
                errors++;
                $display("FAIL scoreboard t=%0t: got h=%0d v=%0d hs=%b vs=%b de=%b tick=%b fs=%b, expected h=%0d v=%0d hs=%b vs=%b de=%b tick=%b fs=%b",
                         $time, c_act.h, c_act.v, c_act.hs, c_act.vs, c_act.de, c_act.tick, c_act.fs,
                         c_exp.h, c_exp.v, c_exp.hs, c_exp.vs, c_exp.de, c_exp.tick, c_exp.fs);
            end
        end
    end

    task automatic test_reset();
        logic [24:0] act;
        logic [24:0] exp;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        act = {o_h_spot, o_v_spot, o_hsync, o_vsync, o_display_on, o_pixel_tick, o_frame_start};
        exp = {10'd0, 10'd0, 5'b11100};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL reset_state: got %h, expected %h", act, exp);
        end
    endtask

    task automatic test_pixel_tick();
        int n;
        rst = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!o_pixel_tick && n < 50);
        checks++;
        if (n != int'(CLK_DIV)) begin
            errors++;
            $display("FAIL first_tick: got %0d clocks after release, expected %0d", n, CLK_DIV);
        end
        checks++;
        if (o_h_spot !== 10'd1) begin
            errors++;
            $display("FAIL first_advance_h: got %0d, expected 1", o_h_spot);
        end
        for (int k = 0; k < 4; k++) begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!o_pixel_tick && n < 50);
            checks++;
            if (n != int'(CLK_DIV)) begin
                errors++;
                $display("FAIL tick_period: got %0d clocks, expected %0d", n, CLK_DIV);
            end
        end
    endtask

    task automatic test_line();
        int n;
        logic [9:0] prev_h, prev_v;
        n = 0;
        while (o_hsync !== 1'b0 && n < int'(2 * LINE)) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (o_h_spot !== 10'(HSS) || o_hsync !== 1'b0) begin
            errors++;
            $display("FAIL hsync_start: got h=%0d hsync=%b, expected h=%0d hsync=0", o_h_spot, o_hsync, HSS);
        end
        n = 0;
        while (o_hsync === 1'b0 && n < int'(2 * LINE)) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n != int'(HS * CLK_DIV)) begin
            errors++;
            $display("FAIL hsync_width: got %0d clocks, expected %0d", n, HS * CLK_DIV);
        end
        n = 0;
        do begin
            prev_h = o_h_spot;
            prev_v = o_v_spot;
            @(negedge clk);
            n++;
        end while (o_h_spot !== 10'd0 && n < int'(2 * LINE));
        checks++;
        if (prev_h !== 10'(HT - 1) || o_v_spot !== 10'((32'(prev_v) + 1) % VT)) begin
            errors++;
            $display("FAIL line_wrap: got h %0d->%0d v %0d->%0d, expected h %0d->0 v +1",
                     prev_h, o_h_spot, prev_v, o_v_spot, HT - 1);
        end
    endtask

    task automatic test_frame();
        int n, cyc, pix, bad, vlow;
        logic [9:0] vs_h, vs_v;
        n = 0;
        while (o_frame_start !== 1'b1 && n < int'(2 * FRAME)) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (o_frame_start !== 1'b1 || o_h_spot !== 10'd0 || o_v_spot !== 10'd0) begin
            errors++;
            $display("FAIL frame_start_origin: got fs=%b h=%0d v=%0d, expected fs=1 h=0 v=0",
                     o_frame_start, o_h_spot, o_v_spot);
        end
        cyc = 0; pix = 0; bad = 0; vlow = 0;
        vs_h = '1; vs_v = '1;
        do begin
            if (o_pixel_tick && o_display_on) begin
                pix++;
                if (o_h_spot >= 10'(HD) || o_v_spot >= 10'(VD)) bad++;
            end
            if (o_vsync === 1'b0) begin
                if (vlow == 0) begin
                    vs_h = o_h_spot;
                    vs_v = o_v_spot;
                end
                vlow++;
            end
            @(negedge clk);
            cyc++;
        end while (o_frame_start !== 1'b1 && cyc < int'(2 * FRAME));
        checks++;
        if (cyc != int'(FRAME)) begin
            errors++;
            $display("FAIL frame_period: got %0d clocks, expected %0d", cyc, FRAME);
        end
        checks++;
        if (pix != int'(HD * VD)) begin
            errors++;
            $display("FAIL visible_pixels: got %0d, expected %0d", pix, HD * VD);
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL display_outside: got %0d pixels, expected 0", bad);
        end
        checks++;
        if (vlow != int'(VS * LINE)) begin
            errors++;
            $display("FAIL vsync_width: got %0d clocks, expected %0d", vlow, VS * LINE);
        end
        checks++;
        if (vs_h !== 10'd0 || vs_v !== 10'(VSS)) begin
            errors++;
            $display("FAIL vsync_start: got h=%0d v=%0d, expected h=0 v=%0d", vs_h, vs_v, VSS);
        end
        @(negedge clk);
        checks++;
        if (o_frame_start !== 1'b0) begin
            errors++;
            $display("FAIL frame_start_width: got %b one clock later, expected 0", o_frame_start);
        end
    endtask

    task automatic test_mid_reset();
        int n;
        logic [24:0] act;
        logic [24:0] exp;
        n = 0;
        while (!(o_h_spot === 10'd12 && o_v_spot === 10'd4) && n < int'(2 * FRAME)) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (o_h_spot !== 10'd12 || o_v_spot !== 10'd4) begin
            errors++;
            $display("FAIL mid_reset_reach: got h=%0d v=%0d, expected h=12 v=4", o_h_spot, o_v_spot);
        end
        rst = 1'b1;
        @(negedge clk);
        act = {o_h_spot, o_v_spot, o_hsync, o_vsync, o_display_on, o_pixel_tick, o_frame_start};
        exp = {10'd0, 10'd0, 5'b11100};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL mid_reset_state: got %h, expected %h", act, exp);
        end
        test_pixel_tick();
    endtask

`ifdef VGA_FRAME_COUNT_EN
    task automatic test_frame_count();
        int n;
        logic [15:0] prev;
        checks++;
        if (o_frame_count !== 16'd0) begin
            errors++;
            $display("FAIL frame_count_reset: got %0d, expected 0", o_frame_count);
        end
        for (int k = 1; k <= 3; k++) begin
            n = 0;
            do begin
                prev = o_frame_count;
                @(negedge clk);
                n++;
            end while (o_frame_start !== 1'b1 && n < int'(2 * FRAME));
            checks++;
            if (prev !== 16'(k - 1) || o_frame_count !== 16'(k)) begin
                errors++;
                $display("FAIL frame_count_step: got %0d->%0d at frame start, expected %0d->%0d",
                         prev, o_frame_count, k - 1, k);
            end
        end
    endtask
`endif

    initial begin
        rst = 1'b1;
        test_reset();
        test_pixel_tick();
        test_line();
        test_frame();
        test_mid_reset();
`ifdef VGA_FRAME_COUNT_EN
        test_frame_count();
`endif
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4: i_clock cycles per pixel (100 MHz to 25 MHz).
REQ-002 SHALL have parameters H_DISPLAY=640, H_FRONT=16, H_SYNC=96, H_BACK=48: horizontal phase lengths in pixels.
REQ-003 SHALL have parameters V_DISPLAY=480, V_FRONT=10, V_SYNC=2, V_BACK=33: vertical phase lengths in lines.
REQ-004 SHALL have one clock and a synchronous, active-high reset.
REQ-005 i_clock  input  1  system clock, 100 MHz.
REQ-006 i_reset  input  1  synchronous active-high reset.
REQ-007 o_hsync  output  1  horizontal sync, active low.
REQ-008 o_vsync  output  1  vertical sync, active low.
REQ-009 o_display_on  output  1  high while the current pixel is in the visible area.
REQ-010 o_h_spot  output  10  current pixel column, 0..799.
REQ-011 o_v_spot  output  10  current pixel row, 0..524.
REQ-012 o_pixel_tick  output  1  one-clock strobe marking the first cycle of each new pixel.
REQ-013 o_frame_start  output  1  one-clock strobe on the first cycle of pixel (0,0).

Function
REQ-014 Divider counts 0..CLK_DIV-1 and wraps; the pixel advance occurs on the clock where the divider equals CLK_DIV-1.
REQ-015 Horizontal counter increments on each pixel advance and wraps from 799 (H total-1) to 0.
REQ-016 Vertical counter increments only on a pixel advance where horizontal wraps, and wraps from 524 to 0; simultaneous wrap of both counters yields (0,0).
REQ-017 Each axis counter tracks its phase in a 4-state FSM: ACTIVE -> FRONT -> SYNC -> BACK -> ACTIVE, transitioning on its phase-length boundary.
REQ-018 o_hsync is 0 exactly when h is in 656..751; o_vsync is 0 exactly when v is in 490..491.
REQ-019 o_display_on is 1 exactly when h<640 and v<480.
REQ-020 All outputs are registered from next-state values, so sync, display_on and spot outputs change in the same cycle and never disagree.
REQ-021 o_pixel_tick is high in the cycle after each pixel advance, i.e. every CLK_DIV clocks, for exactly one clock.
REQ-022 o_frame_start is high for one clock when (h,v) becomes (0,0) after a wrap; it is not asserted at reset release.
REQ-023 Line period is 3200 clocks; frame period is 1,680,000 clocks (about 59.5 Hz).

Reset
REQ-024 While i_reset is high at a clock edge: divider=0, h=0, v=0, FSMs=ACTIVE, o_hsync=1, o_vsync=1, o_display_on=1, o_pixel_tick=0, o_frame_start=0.
REQ-025 Reset asserted mid-frame returns to the REQ-024 state on the next edge; the first pixel advance occurs CLK_DIV clocks after reset deasserts.

Configuration
REQ-026 Macro VGA_FRAME_COUNT_EN: when defined, the block adds output o_frame_count (16 bits, reset 0) that increments, wrapping at 65535, in the same cycle o_frame_start asserts.
REQ-027 Without VGA_FRAME_COUNT_EN, the port and the counter are absent and all other behaviour is identical.

Structure
REQ-028 Package vga_timing_pkg holds the phase-length constants, H/V totals, sync start/end values, and the phase FSM enum (ACTIVE, FRONT, SYNC, BACK).
REQ-029 Sub-module vga_axis_counter (count, wrap, phase FSM, sync-active flag, visible flag) is instantiated twice, once for the horizontal axis and once for the vertical axis.

Verification
REQ-030 Release reset, count clocks -> o_pixel_tick first high 4 clocks after release, then every 4 clocks; h goes 0->1 on the first advance.
REQ-031 Run one line -> o_hsync low for exactly 384 clocks starting when h=656; h wraps 799->0 and v increments 0->1 in the same cycle.
REQ-032 Run one frame -> o_vsync low for exactly 6400 clocks starting at v=490,h=0; o_frame_start pulses once, 1,680,000 clocks after the previous pulse.
REQ-033 Sample every pixel for one frame -> o_display_on high for exactly 307,200 pixels and never high when h>=640 or v>=480.
REQ-034 Assert i_reset for 1 clock at h=700,v=300 -> next cycle outputs match the REQ-024 values; timing then restarts per REQ-030.
REQ-035 With VGA_FRAME_COUNT_EN defined, run 3 frames -> o_frame_count reads 1, 2, 3, each step coinciding with o_frame_start; preload 65535 -> wraps to 0.
